// File: rtl/rot_arbiter.sv
// Round-robin front end that shares one 8-bit rotate-right unit between two
// valid/ready requesters, with a one-entry output register tagged by requester.

module rot8 (
  input  logic [7:0] data,
  input  logic [2:0] amt,
  output logic [7:0] result
);

  logic [15:0] doubled;

  // Shifting the operand concatenated with itself wraps the low bits around.
  assign doubled = {data, data} >> amt;
  assign result  = doubled[7:0];

endmodule

module rot_arbiter #(
  parameter logic FIRST_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  input  logic [2:0] req_amt0,
  input  logic [2:0] req_amt1,
  input  logic       req_left0,
  input  logic       req_left1,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_id,
  output logic [7:0] done_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state;
  logic       last;
  logic       slot;
  logic [1:0] grant;
  logic       gid;
  logic       accept;
  logic       out_xfer;
  logic [7:0] sel_data;
  logic [2:0] sel_amt;
  logic       sel_left;
  logic [2:0] rot_amt;
  logic [7:0] rot_data;

  assign out_valid = (state == FULL);
  assign slot      = !out_valid || out_ready;
  assign out_xfer  = out_valid && out_ready;

  // Under contention the requester that did not win last time goes next.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign req_ready = (slot && reset_n) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign gid       = grant[1];

  assign sel_data = gid ? req_data1 : req_data0;
  assign sel_amt  = gid ? req_amt1  : req_amt0;
  assign sel_left = gid ? req_left1 : req_left0;

  // A left rotate by n is a right rotate by (8 - n) mod 8.
  assign rot_amt = sel_left ? (3'd0 - sel_amt) : sel_amt;

  rot8 u_rot8 (
    .data   (sel_data),
    .amt    (rot_amt),
    .result (rot_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= EMPTY;
      out_data <= 8'h00;
      out_id   <= 1'b0;
      last     <= ~FIRST_PRIO;
      done_cnt <= 8'h00;
    end else begin
      if (out_xfer) begin
        done_cnt <= done_cnt + 8'd1;
      end
      if (accept) begin
        state    <= FULL;
        out_data <= rot_data;
        out_id   <= gid;
        last     <= gid;
      end else if (out_xfer) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_rot_arbiter.sv
// Self-checking bench for rot_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural model of the arbiter and rotator.

module tb_rot_arbiter;

  logic       clk;
  logic       reset_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_data0, req_data1;
  logic [2:0] req_amt0, req_amt1;
  logic       req_left0, req_left1;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_id;
  logic [7:0] done_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit       m_valid;
  bit [7:0] m_data;
  bit       m_id;
  bit       m_last;
  int       m_cnt;

  rot_arbiter #(.FIRST_PRIO(1'b0)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_amt0  (req_amt0),
    .req_amt1  (req_amt1),
    .req_left0 (req_left0),
    .req_left1 (req_left1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-by-bit rotation: right moves bit (i+a)%8 to i, left moves bit i to (i+a)%8.
  function automatic logic [7:0] ref_rot(input logic [7:0] d, input int a, input logic left);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (left) r[(i + a) % 8] = d[i];
      else      r[i] = d[(i + a) % 8];
    end
    return r;
  endfunction

  function automatic logic [1:0] ref_ready();
    int winner;
    if (!reset_n || !(!m_valid || out_ready)) return 2'b00;
    if (req_valid == 2'b00) return 2'b00;
    if (req_valid == 2'b11) winner = m_last ? 0 : 1;
    else winner = req_valid[1] ? 1 : 0;
    return (winner == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic model_edge();
    logic [1:0] rdy;
    bit xfer;
    rdy  = ref_ready();
    xfer = m_valid && out_ready;
    if (!reset_n) begin
      m_valid = 0; m_data = 8'h00; m_id = 0; m_last = 1; m_cnt = 0;
    end else begin
      if (xfer) m_cnt = (m_cnt + 1) % 256;
      if (rdy != 2'b00) begin
        m_id    = rdy[1];
        m_last  = rdy[1];
        m_valid = 1;
        m_data  = rdy[1] ? ref_rot(req_data1, int'(req_amt1), req_left1)
                         : ref_rot(req_data0, int'(req_amt0), req_left0);
      end else if (xfer) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 2'b11; out_ready = 1'b1;
    tick();
    #1;
    n_checks++;
    if (req_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_ready got %b exp 00", req_ready); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got %b exp 0", out_valid); end
    n_checks++;
    if (out_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_data got %h exp 00", out_data); end
    n_checks++;
    if (out_id !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_id got %b exp 0", out_id); end
    n_checks++;
    if (done_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_cnt got %0d exp 0", done_cnt); end
    reset_n = 1'b1; req_valid = 2'b00;
  endtask

  task automatic test_right_rotate();
    req_valid = 2'b01; req_data0 = 8'h81; req_amt0 = 3'd1; req_left0 = 1'b0; out_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL rr_ready got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hC0 || out_id !== 1'b0)
      begin n_fail++; $display("[TB] FAIL rr_out got v%b d%h id%b exp v1 dc0 id0", out_valid, out_data, out_id); end
    tick();
    n_checks++;
    if (done_cnt !== 8'd1 || out_valid !== 1'b0)
      begin n_fail++; $display("[TB] FAIL rr_cnt got cnt%0d v%b exp cnt1 v0", done_cnt, out_valid); end
  endtask

  task automatic test_left_zero();
    req_valid = 2'b10; req_data1 = 8'h81; req_amt1 = 3'd1; req_left1 = 1'b1; out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_data !== 8'h03 || out_id !== 1'b1)
      begin n_fail++; $display("[TB] FAIL left1 got d%h id%b exp d03 id1", out_data, out_id); end
    req_data1 = 8'hA5; req_amt1 = 3'd0;
    tick();
    n_checks++;
    if (out_data !== 8'hA5 || out_id !== 1'b1)
      begin n_fail++; $display("[TB] FAIL left_zero got d%h id%b exp da5 id1", out_data, out_id); end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    req_valid = 2'b11; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_data0 = 8'($urandom); req_data1 = 8'($urandom);
      req_amt0 = 3'($urandom); req_amt1 = 3'($urandom);
      #1;
      n_checks++;
      if (req_ready !== exp_rdy[k]) begin n_fail++; $display("[TB] FAIL rr_grant%0d got %b exp %b", k, req_ready, exp_rdy[k]); end
      tick();
      n_checks++;
      if (out_id !== exp_rdy[k][1] || out_data !== m_data)
        begin n_fail++; $display("[TB] FAIL rr_id%0d got id%b d%h exp id%b d%h", k, out_id, out_data, exp_rdy[k][1], m_data); end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] held_data;
    logic       held_id;
    logic [7:0] held_cnt;
    req_valid = 2'b11; out_ready = 1'b1;
    tick();
    held_data = m_data; held_id = m_id; held_cnt = 8'(m_cnt);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_data0 = 8'($urandom); req_data1 = 8'($urandom);
      #1;
      n_checks++;
      if (req_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL bp_ready%0d got %b exp 00", k, req_ready); end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== held_data || out_id !== held_id || done_cnt !== held_cnt)
        begin n_fail++; $display("[TB] FAIL bp_hold%0d got v%b d%h id%b c%0d exp v1 d%h id%b c%0d",
                                 k, out_valid, out_data, out_id, done_cnt, held_data, held_id, held_cnt); end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== ref_ready() || req_ready === 2'b00)
      begin n_fail++; $display("[TB] FAIL bp_release_ready got %b exp %b", req_ready, ref_ready()); end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || done_cnt !== 8'(held_cnt + 8'd1) || out_data !== m_data)
      begin n_fail++; $display("[TB] FAIL bp_reload got v%b c%0d d%h exp v1 c%0d d%h",
                               out_valid, done_cnt, out_data, held_cnt + 8'd1, m_data); end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b01; req_data0 = 8'h5A; req_amt0 = 3'd3; out_ready = 1'b0;
    tick();
    req_valid = 2'b00;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || done_cnt !== 8'd0)
      begin n_fail++; $display("[TB] FAIL mid_reset got v%b d%h c%0d exp v0 d00 c0", out_valid, out_data, done_cnt); end
    req_valid = 2'b11; out_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL mid_reset_prio got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_exhaustive();
    logic [7:0] exp;
    req_valid = 2'b01; out_ready = 1'b1; req_data0 = 8'h01;
    for (int dir = 0; dir < 2; dir++) begin
      for (int a = 0; a < 8; a++) begin
        req_amt0 = 3'(a); req_left0 = dir[0];
        tick();
        exp = 8'h01 << (dir == 1 ? a : (8 - a) % 8);
        n_checks++;
        if (out_data !== exp) begin n_fail++; $display("[TB] FAIL exh_l%0d_a%0d got %h exp %h", dir, a, out_data, exp); end
      end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_counter_wrap();
    int xfers = 0;
    int cyc = 0;
    do_reset();
    req_valid = 2'b01; out_ready = 1'b1;
    while (xfers < 256 && cyc < 400) begin
      req_data0 = 8'($urandom); req_amt0 = 3'($urandom); req_left0 = 1'($urandom);
      if (m_valid) xfers++;
      tick();
      cyc++;
      if (xfers == 255) begin
        n_checks++;
        if (done_cnt !== 8'd255) begin n_fail++; $display("[TB] FAIL wrap_255 got %0d exp 255", done_cnt); end
      end
    end
    n_checks++;
    if (xfers != 256) begin n_fail++; $display("[TB] FAIL wrap_timeout got %0d xfers exp 256", xfers); end
    n_checks++;
    if (done_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL wrap_zero got %0d exp 0", done_cnt); end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_random();
    logic [1:0] exp_rdy;
    for (int k = 0; k < 300; k++) begin
      req_valid = 2'($urandom);
      req_data0 = 8'($urandom); req_data1 = 8'($urandom);
      req_amt0 = 3'($urandom); req_amt1 = 3'($urandom);
      req_left0 = 1'($urandom); req_left1 = 1'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      exp_rdy = ref_ready();
      n_checks++;
      if (req_ready !== exp_rdy) begin n_fail++; $display("[TB] FAIL rnd_ready%0d got %b exp %b", k, req_ready, exp_rdy); end
      tick();
      n_checks++;
      if (out_valid !== m_valid || done_cnt !== 8'(m_cnt) ||
          (m_valid && (out_data !== m_data || out_id !== m_id)))
        begin n_fail++; $display("[TB] FAIL rnd_out%0d got v%b d%h id%b c%0d exp v%b d%h id%b c%0d",
                                 k, out_valid, out_data, out_id, done_cnt, m_valid, m_data, m_id, m_cnt); end
    end
    req_valid = 2'b00;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 2'b00; out_ready = 1'b0;
    req_data0 = 8'h00; req_data1 = 8'h00; req_amt0 = 3'd0; req_amt1 = 3'd0;
    req_left0 = 1'b0; req_left1 = 1'b0;
    m_valid = 0; m_data = 8'h00; m_id = 0; m_last = 1; m_cnt = 0;
    $display("[TB] starting rot_arbiter bench");
    test_reset();
    test_right_rotate();
    test_left_zero();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_exhaustive();
    test_counter_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
